// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, the x0 register constant and the buffered LLU result entry.
package wb_port_arbiter_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] X0 = '0;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the writeback stage, the LLU and the register-file port.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;

    // An LLU result transfers in any cycle where llu_valid && llu_ready; llu_valid
    // and the payload hold until that cycle, and llu_ready does not depend on llu_valid.
    logic          llu_valid;
    logic [AW-1:0] llu_rd;
    logic [DW-1:0] llu_data;
    logic          llu_ready;

    logic          stall_pipe;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pend_busy;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, llu_valid, llu_rd, llu_data,
        output llu_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, pend_busy
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, llu_valid, llu_rd, llu_data,
        input  llu_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, pend_busy
    );

endinterface

// File: rtl/wb_llu_fifo.sv
// DEPTH-entry LLU result buffer; every entry can be killed by a younger write to its rd.
module wb_llu_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_entry,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_rd,
    output entry_t        head,
    output logic          empty,
    output logic          full,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    entry_t      mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Popped slots have their live bit cleared, so only occupied slots can be live.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | mem[i].live;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem[i].rd == kill_rd)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr[PW-1:0]].live <= 1'b0;
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered LLU results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    entry_t        head;
    entry_t        push_entry;
    logic          empty;
    logic          full;
    logic          busy;
    logic          pipe_eff;
    logic          head_ok;
    logic          grant_head;
    logic          pop;
    logic          push;
    logic          stall_q;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cnt_next;

    assign pipe_eff   = bus.pipe_we && (bus.pipe_waddr != X0) && !stall_q;
    assign head_ok    = !empty && head.live && (head.rd != X0);
    assign grant_head = !pipe_eff && head_ok;
    // Dead or x0 heads leave without touching the port.
    assign pop        = !empty && (grant_head || !head.live || (head.rd == X0));
    assign push       = bus.llu_valid && !full;

    // The pipe write is younger, so a same-cycle LLU result to the same rd is born dead.
    always_comb begin
        push_entry      = '0;
        push_entry.live = !(pipe_eff && (bus.pipe_waddr == bus.llu_rd));
        push_entry.rd   = bus.llu_rd;
        push_entry.data = bus.llu_data;
    end

    wb_llu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (pipe_eff),
        .kill_rd    (bus.pipe_waddr),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .busy       (busy)
    );

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (pipe_eff) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.pipe_waddr;
            bus.rf_wdata = bus.pipe_wdata;
        end else if (grant_head) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = head.rd;
            bus.rf_wdata = head.data;
        end
    end

    // A head still in place is live and was passed over by the pipe.
    always_comb begin
        cnt_next = '0;
        if (!empty && !pop) begin
            cnt_next = wait_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            wait_cnt <= cnt_next;
            stall_q  <= (cnt_next == CW'(STARVE_LIMIT));
        end
    end

    assign bus.stall_pipe = stall_q;
    assign bus.llu_ready  = !full;
    assign bus.pend_busy  = busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: expected buffer contents {live, rd[4:0], data[31:0]}
    logic [37:0] exp_q[$];
    int          m_wait;
    bit          m_stall;

    always @(negedge clk) begin
        bit          peff;
        bit          has;
        bit          grant;
        bit          pop;
        bit          push;
        bit          any_live;
        logic [37:0] h;
        logic [37:0] ne;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        if (rst) begin
            exp_q.delete();
            m_wait  = 0;
            m_stall = 0;
        end
        peff  = bus.pipe_we && (bus.pipe_waddr != 5'd0) && !m_stall;
        has   = (exp_q.size() > 0);
        h     = has ? exp_q[0] : 38'd0;
        grant = !peff && has && h[37] && (h[36:32] != 5'd0);
        e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        if (peff) begin
            e_we = 1'b1; e_addr = bus.pipe_waddr; e_data = bus.pipe_wdata;
        end else if (grant) begin
            e_we = 1'b1; e_addr = h[36:32]; e_data = h[31:0];
        end
        any_live = 1'b0;
        foreach (exp_q[i]) if (exp_q[i][37]) any_live = 1'b1;
        check("stall_pipe", 32'(bus.stall_pipe), 32'(m_stall));
        check("llu_ready", 32'(bus.llu_ready), 32'(exp_q.size() < DEPTH));
        check("pend_busy", 32'(bus.pend_busy), 32'(any_live));
        check("rf_we", 32'(bus.rf_we), 32'(e_we));
        check("rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
        check("rf_wdata", bus.rf_wdata, e_data);
        if (!rst) begin
            pop  = has && (grant || !h[37] || (h[36:32] == 5'd0));
            push = bus.llu_valid && (exp_q.size() < DEPTH);
            if (peff) begin
                foreach (exp_q[i]) if (exp_q[i][36:32] == bus.pipe_waddr) exp_q[i][37] = 1'b0;
            end
            m_wait = (!has || pop) ? 0 : m_wait + 1;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                ne = {!(peff && bus.pipe_waddr == bus.llu_rd), bus.llu_rd, bus.llu_data};
                exp_q.push_back(ne);
            end
            m_stall = (m_wait == STARVE_LIMIT);
        end
    end

    // driver tasks
    task automatic drive(input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input bit lv, input logic [4:0] lr, input logic [31:0] ld);
        @(posedge clk);
        #1;
        bus.pipe_we    = pwe;
        bus.pipe_waddr = pa;
        bus.pipe_wdata = pd;
        bus.llu_valid  = lv;
        bus.llu_rd     = lr;
        bus.llu_data   = ld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.llu_valid = 1'b0; bus.llu_rd = '0; bus.llu_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset llu_ready", 32'(bus.llu_ready), 32'd1);
        check("reset rf_we", 32'(bus.rf_we), 32'd0);

        // single LLU result into an idle port
        drive(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
        idle(1);
        #1;
        check("t1 rf_we", 32'(bus.rf_we), 32'd1);
        check("t1 rf_waddr", 32'(bus.rf_waddr), 32'd5);
        check("t1 rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("t1 pend_busy", 32'(bus.pend_busy), 32'd1);
        idle(1);
        #1;
        check("t1 pend_busy fall", 32'(bus.pend_busy), 32'd0);

        // busy pipe starves a full buffer until the forced stall
        for (int c = 0; c < 14; c++) begin
            drive(1, 5'd20, $urandom, c <= 10, (c < 4) ? 5'(c + 1) : 5'd5, 32'h1000 + 32'(c));
            #1;
            if (c == 4 || c == 9) check("t2 llu_ready low", 32'(bus.llu_ready), 32'd0);
            if (c == 10) check("t2 llu_ready back", 32'(bus.llu_ready), 32'd1);
            if (c == 8 || c == 10) check("t2 stall low", 32'(bus.stall_pipe), 32'd0);
            if (c == 9) begin
                check("t2 stall high", 32'(bus.stall_pipe), 32'd1);
                check("t2 head addr", 32'(bus.rf_waddr), 32'd1);
                check("t2 head data", bus.rf_wdata, 32'h1000);
            end
        end
        idle(8);

        // buffered rd=7 killed by a younger pipe write
        drive(1, 5'd9, 32'h9, 1, 5'd7, 32'h7777);
        drive(1, 5'd7, 32'h1, 0, 5'd0, 32'd0);
        idle(1);
        #1;
        check("t3 rf_we", 32'(bus.rf_we), 32'd0);
        check("t3 pend_busy", 32'(bus.pend_busy), 32'd0);

        // same-cycle collision on rd=3
        drive(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB);
        #1;
        check("t4 rf_wdata", bus.rf_wdata, 32'hAAAA);
        idle(1);
        #1;
        check("t4 rf_we", 32'(bus.rf_we), 32'd0);

        // x0 on both sides
        drive(1, 5'd0, 32'h5, 1, 5'd0, 32'h6);
        #1;
        check("t5 rf_we now", 32'(bus.rf_we), 32'd0);
        idle(1);
        #1;
        check("t5 rf_we next", 32'(bus.rf_we), 32'd0);
        idle(1);

        // fill, drain, refill across the wrap, reset mid-drain
        for (int i = 0; i < DEPTH; i++) drive(1, 5'd21, $urandom, 1, 5'(11 + i), $urandom);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(1, 5'd21, $urandom, 1, 5'(15 + i), $urandom);
        idle(2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6 rst rf_we", 32'(bus.rf_we), 32'd0);
        check("t6 rst pend_busy", 32'(bus.pend_busy), 32'd0);
        check("t6 rst llu_ready", 32'(bus.llu_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // reset landing on a stall cycle
        drive(1, 5'd22, 32'h2, 1, 5'd6, 32'h6666);
        for (int c = 1; c <= 9; c++) drive(1, 5'd22, 32'h2, 0, 5'd0, 32'd0);
        #1;
        check("t7 stall high", 32'(bus.stall_pipe), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t7 stall async drop", 32'(bus.stall_pipe), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(12);
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
